// File: rtl/alu_pkg.sv
// alu_pkg: shared types, frame constants and the CRC3 helper for the ALU
// response path. The CRC function is also used by verification code.
package alu_pkg;

   localparam int         FRAME_BITS = 11;
   localparam logic [2:0] CRC3_POLY  = 3'b011;

   typedef enum logic [1:0] {
      DATA_FR,
      CTL_FR,
      ERR_FR
   } frame_type_t;

   typedef enum logic [2:0] {
      WAIT_D0,
      WAIT_D1,
      WAIT_D2,
      WAIT_D3,
      WAIT_CTL
   } resp_state_t;

   // CRC3, polynomial x^3+x+1, init 000, MSB of 'bits' processed first.
   function automatic logic [2:0] calc_crc3(input logic [36:0] bits);
      logic [2:0] crc;
      logic       fb;
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ bits[i];
         crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
      end
      return crc;
   endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// alu_frame_rx: bit-level receiver for 11-bit frames on the ALU serial line.
// Frame: start(0), type, payload[7:0] MSB first, stop(1).
// frame_done is combinational in the cycle the stop bit is on the line, so
// the packet logic can register its result on that same clock edge.
// Build macro ALU_RESP_TIMEOUT_EN exposes o_busy for the inter-frame timeout.
module alu_frame_rx
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_sout,
`ifdef ALU_RESP_TIMEOUT_EN
   output logic        o_busy,
`endif
   output logic        o_frame_done,
   output frame_type_t o_frame_type,
   output logic [7:0]  o_payload,
   output logic        o_stop_ok
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   logic       r_busy;
   logic [3:0] r_cnt;
   logic [8:0] r_shift;

   // Bit counter and type/payload shift register; idle until a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_cnt   <= 4'd0;
         r_shift <= 9'd0;
      end else if (!r_busy) begin
         if (!i_sout) begin
            r_busy <= 1'b1;
            r_cnt  <= 4'd1;
         end
      end else if (r_cnt == LAST_BIT) begin
         // Stop bit is consumed combinationally; back to idle so a start
         // bit on the very next cycle is accepted.
         r_busy <= 1'b0;
         r_cnt  <= 4'd0;
      end else begin
         r_shift <= {r_shift[7:0], i_sout};
         r_cnt   <= r_cnt + 4'd1;
      end
   end

   assign o_frame_done = r_busy && (r_cnt == LAST_BIT);
   assign o_stop_ok    = i_sout;
   assign o_payload    = r_shift[7:0];
`ifdef ALU_RESP_TIMEOUT_EN
   assign o_busy       = r_busy;
`endif

   // Frame classification from the type bit and payload MSB
   always_comb begin
      o_frame_type = DATA_FR;
      if (r_shift[8]) begin
         o_frame_type = r_shift[7] ? ERR_FR : CTL_FR;
      end
   end

endmodule

// File: rtl/alu_resp_deserializer.sv
// alu_resp_deserializer: assembles ALU response frames into a 4-byte result
// plus control frame, or a single error frame, and checks CRC3/parity.
// Build macro ALU_RESP_TIMEOUT_EN: abandon a partial packet after
// TIMEOUT_CYCLES idle line cycles between its frames.
module alu_resp_deserializer
   import alu_pkg::*;
`ifdef ALU_RESP_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 64
)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sout,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic [3:0]  res_flags,
   output logic        res_crc_ok,
   output logic        err_valid,
   output logic [5:0]  err_flags,
   output logic        err_parity_ok,
   output logic        frame_err
);

   logic        w_frame_done;
   frame_type_t w_frame_type;
   logic [7:0]  w_payload;
   logic        w_stop_ok;
   logic        w_timeout;
   logic        w_crc_ok;
   logic        w_parity_ok;
   resp_state_t w_next_data_state;

   resp_state_t r_state;
   logic [31:0] r_data;
   logic        r_res_valid;
   logic [31:0] r_res_data;
   logic [3:0]  r_res_flags;
   logic        r_res_crc_ok;
   logic        r_err_valid;
   logic [5:0]  r_err_flags;
   logic        r_err_parity_ok;
   logic        r_frame_err;

`ifdef ALU_RESP_TIMEOUT_EN
   logic        w_busy;
`endif

   alu_frame_rx u_frame_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_sout       (sout),
`ifdef ALU_RESP_TIMEOUT_EN
      .o_busy       (w_busy),
`endif
      .o_frame_done (w_frame_done),
      .o_frame_type (w_frame_type),
      .o_payload    (w_payload),
      .o_stop_ok    (w_stop_ok)
   );

   // Control frame: the four data bytes, a zero pad bit and the flags are covered
   assign w_crc_ok = (calc_crc3({r_data, 1'b0, w_payload[6:3]}) == w_payload[2:0]);

   // Error frame: parity bit is set when {1'b1, err_flags} holds an even number of ones
   assign w_parity_ok = (w_payload[0] == ~^{1'b1, w_payload[6:1]});

`ifdef ALU_RESP_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            w_to_run;

   // Count only true idle line cycles inside a partial packet; a start bit clears
   assign w_to_run  = (r_state != WAIT_D0) && !w_busy && sout;
   assign w_timeout = w_to_run && (r_to_cnt == TO_LAST);

   // Inter-frame idle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (!w_to_run || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Successor state after accepting a data byte
   always_comb begin
      w_next_data_state = WAIT_D0;
      case (r_state)
         WAIT_D0: w_next_data_state = WAIT_D1;
         WAIT_D1: w_next_data_state = WAIT_D2;
         WAIT_D2: w_next_data_state = WAIT_D3;
         WAIT_D3: w_next_data_state = WAIT_CTL;
         default: w_next_data_state = WAIT_D0;
      endcase
   end

   // Packet FSM: consume at most one completed frame per cycle and update outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= WAIT_D0;
         r_data          <= 32'd0;
         r_res_valid     <= 1'b0;
         r_res_data      <= 32'd0;
         r_res_flags     <= 4'd0;
         r_res_crc_ok    <= 1'b0;
         r_err_valid     <= 1'b0;
         r_err_flags     <= 6'd0;
         r_err_parity_ok <= 1'b0;
         r_frame_err     <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         r_err_valid <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_frame_done) begin
            if (!w_stop_ok) begin
               // Bad stop bit: drop the frame and any partial packet
               r_frame_err <= 1'b1;
               r_state     <= WAIT_D0;
            end else begin
               case (r_state)
                  WAIT_D0: begin
                     if (w_frame_type == DATA_FR) begin
                        r_data  <= {r_data[23:0], w_payload};
                        r_state <= w_next_data_state;
                     end else if (w_frame_type == ERR_FR) begin
                        r_err_flags     <= w_payload[6:1];
                        r_err_parity_ok <= w_parity_ok;
                        r_err_valid     <= 1'b1;
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                  end
                  WAIT_D1, WAIT_D2, WAIT_D3: begin
                     if (w_frame_type == DATA_FR) begin
                        r_data  <= {r_data[23:0], w_payload};
                        r_state <= w_next_data_state;
                     end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= WAIT_D0;
                     end
                  end
                  WAIT_CTL: begin
                     if (w_frame_type == CTL_FR) begin
                        r_res_data   <= r_data;
                        r_res_flags  <= w_payload[6:3];
                        r_res_crc_ok <= w_crc_ok;
                        r_res_valid  <= 1'b1;
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                     r_state <= WAIT_D0;
                  end
                  default: begin
                     r_frame_err <= 1'b1;
                     r_state     <= WAIT_D0;
                  end
               endcase
            end
         end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= WAIT_D0;
         end
      end
   end

   assign res_valid     = r_res_valid;
   assign res_data      = r_res_data;
   assign res_flags     = r_res_flags;
   assign res_crc_ok    = r_res_crc_ok;
   assign err_valid     = r_err_valid;
   assign err_flags     = r_err_flags;
   assign err_parity_ok = r_err_parity_ok;
   assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_alu_resp_deserializer.sv
// tb_alu_resp_deserializer: directed bench for the ALU response deserializer.
// Inputs change on the falling edge; outputs are sampled 1 time unit after it.
module tb_alu_resp_deserializer;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        sout;
   logic        res_valid;
   logic [31:0] res_data;
   logic [3:0]  res_flags;
   logic        res_crc_ok;
   logic        err_valid;
   logic [5:0]  err_flags;
   logic        err_parity_ok;
   logic        frame_err;

   int checks   = 0;
   int failures = 0;
   int n_res    = 0;
   int n_err    = 0;
   int n_ferr   = 0;
   int n_multi  = 0;

   alu_resp_deserializer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sout          (sout),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .res_flags     (res_flags),
      .res_crc_ok    (res_crc_ok),
      .err_valid     (err_valid),
      .err_flags     (err_flags),
      .err_parity_ok (err_parity_ok),
      .frame_err     (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Running totals of every pulse seen, plus cycles with more than one pulse
   always @(negedge clk) begin
      if (res_valid === 1'b1) n_res++;
      if (err_valid === 1'b1) n_err++;
      if (frame_err === 1'b1) n_ferr++;
      if ($countones({res_valid === 1'b1, err_valid === 1'b1, frame_err === 1'b1}) > 1) n_multi++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      sout = b;
   endtask

   task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
      send_bit(1'b0);
      send_bit(typ);
      for (int i = 7; i >= 0; i--) send_bit(pl[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_packet(input logic [31:0] d, input logic [7:0] ctl);
      send_frame(1'b0, d[31:24], 1'b1);
      send_frame(1'b0, d[23:16], 1'b1);
      send_frame(1'b0, d[15:8],  1'b1);
      send_frame(1'b0, d[7:0],   1'b1);
      send_frame(1'b1, ctl,      1'b1);
   endtask

   // Cycle after the stop bit: expected pulses; the cycle after that: all low
   task automatic post_frame(input string tag, input logic rv, input logic ev, input logic fe);
      send_bit(1'b1);
      #1;
      check({tag, "_res_valid"}, res_valid, rv);
      check({tag, "_err_valid"}, err_valid, ev);
      check({tag, "_frame_err"}, frame_err, fe);
      send_bit(1'b1);
      #1;
      check({tag, "_pulse_end"}, {res_valid, err_valid, frame_err}, 3'b000);
   endtask

   initial begin
      sout  = 1'b1;
      rst_n = 1'b0;

      // CRC helper against hand-computed remainders
      check("crc_fn_05",   calc_crc3({32'h0000_0005, 1'b0, 4'b0000}), 3'b001);
      check("crc_fn_dead", calc_crc3({32'hDEAD_BEEF, 1'b0, 4'b0000}), 3'b011);
      check("crc_fn_05a",  calc_crc3({32'h0000_0005, 1'b0, 4'b1010}), 3'b010);

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_res_valid",     res_valid, 1'b0);
      check("rst_res_data",      res_data, 32'h0);
      check("rst_res_flags",     res_flags, 4'h0);
      check("rst_res_crc_ok",    res_crc_ok, 1'b0);
      check("rst_err_valid",     err_valid, 1'b0);
      check("rst_err_flags",     err_flags, 6'h0);
      check("rst_err_parity_ok", err_parity_ok, 1'b0);
      check("rst_frame_err",     frame_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      // Good packet 0x00000005, flags 0, CRC 001
      send_packet(32'h0000_0005, 8'h01);
      post_frame("pktA", 1'b1, 1'b0, 1'b0);
      check("pktA_data",   res_data, 32'h0000_0005);
      check("pktA_flags",  res_flags, 4'h0);
      check("pktA_crc_ok", res_crc_ok, 1'b1);

      // Same packet, CRC inverted (110)
      send_packet(32'h0000_0005, 8'h06);
      post_frame("pktB", 1'b1, 1'b0, 1'b0);
      check("pktB_data",   res_data, 32'h0000_0005);
      check("pktB_crc_ok", res_crc_ok, 1'b0);

      // Error frame, err_flags 100100, parity 0 (correct)
      send_frame(1'b1, 8'hC8, 1'b1);
      post_frame("errA", 1'b0, 1'b1, 1'b0);
      check("errA_flags",     err_flags, 6'h24);
      check("errA_parity_ok", err_parity_ok, 1'b1);
      check("errA_res_hold",  res_data, 32'h0000_0005);

      // Error frame with wrong parity
      send_frame(1'b1, 8'hC9, 1'b1);
      post_frame("errB", 1'b0, 1'b1, 1'b0);
      check("errB_flags",     err_flags, 6'h24);
      check("errB_parity_ok", err_parity_ok, 1'b0);

      // Control frame after only two data bytes
      send_frame(1'b0, 8'h11, 1'b1);
      send_frame(1'b0, 8'h22, 1'b1);
      send_frame(1'b1, 8'h01, 1'b1);
      post_frame("shortpkt", 1'b0, 1'b0, 1'b1);
      check("shortpkt_hold", res_data, 32'h0000_0005);

      // Full packet following the violation, CRC 011
      send_packet(32'hDEAD_BEEF, 8'h03);
      post_frame("pktC", 1'b1, 1'b0, 1'b0);
      check("pktC_data",   res_data, 32'hDEAD_BEEF);
      check("pktC_flags",  res_flags, 4'h0);
      check("pktC_crc_ok", res_crc_ok, 1'b1);

      // Data frame with stop bit 0
      send_frame(1'b0, 8'h77, 1'b0);
      post_frame("badstop", 1'b0, 1'b0, 1'b1);

      // Fifth data frame where the control frame is due
      send_frame(1'b0, 8'h01, 1'b1);
      send_frame(1'b0, 8'h02, 1'b1);
      send_frame(1'b0, 8'h03, 1'b1);
      send_frame(1'b0, 8'h04, 1'b1);
      send_frame(1'b0, 8'h05, 1'b1);
      post_frame("datainctl", 1'b0, 1'b0, 1'b1);
      check("datainctl_hold", res_data, 32'hDEAD_BEEF);

      // Asynchronous reset in the middle of the third data byte
      send_frame(1'b0, 8'hAA, 1'b1);
      send_frame(1'b0, 8'hBB, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      #1;
      check("midrst_pre_data", res_data, 32'hDEAD_BEEF);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_res_data",  res_data, 32'h0);
      check("midrst_err_flags", err_flags, 6'h0);
      check("midrst_err_par",   err_parity_ok, 1'b0);
      check("midrst_crc_ok",    res_crc_ok, 1'b0);
      sout = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      // Packet after reset, flags 1010, CRC 010
      send_packet(32'h0000_0005, 8'h52);
      post_frame("pktD", 1'b1, 1'b0, 1'b0);
      check("pktD_data",   res_data, 32'h0000_0005);
      check("pktD_flags",  res_flags, 4'hA);
      check("pktD_crc_ok", res_crc_ok, 1'b1);

`ifdef ALU_RESP_TIMEOUT_EN
      // 64 idle cycles after one data byte
      send_frame(1'b0, 8'h10, 1'b1);
      idle(64);
      #1;
      check("to64_before", frame_err, 1'b0);
      send_bit(1'b1);
      #1;
      check("to64_fire", frame_err, 1'b1);
      send_bit(1'b1);
      #1;
      check("to64_pulse_end", frame_err, 1'b0);

      // 63 idle cycles: packet must still complete
      send_frame(1'b0, 8'h00, 1'b1);
      idle(63);
      send_frame(1'b0, 8'h00, 1'b1);
      send_frame(1'b0, 8'h00, 1'b1);
      send_frame(1'b0, 8'h05, 1'b1);
      send_frame(1'b1, 8'h01, 1'b1);
      post_frame("gap63", 1'b1, 1'b0, 1'b0);
      check("gap63_data", res_data, 32'h0000_0005);
`else
      // Without the timeout a partial packet waits indefinitely
      send_frame(1'b0, 8'h00, 1'b1);
      idle(200);
      #1;
      check("longgap_no_err", frame_err, 1'b0);
      send_frame(1'b0, 8'h00, 1'b1);
      send_frame(1'b0, 8'h00, 1'b1);
      send_frame(1'b0, 8'h05, 1'b1);
      send_frame(1'b1, 8'h01, 1'b1);
      post_frame("longgap", 1'b1, 1'b0, 1'b0);
      check("longgap_data", res_data, 32'h0000_0005);
`endif

      // Pulse totals over the whole run
      idle(4);
      #2;
      check("total_res_valid", n_res, 5);
      check("total_err_valid", n_err, 2);
`ifdef ALU_RESP_TIMEOUT_EN
      check("total_frame_err", n_ferr, 4);
`else
      check("total_frame_err", n_ferr, 3);
`endif
      check("total_multi_pulse", n_multi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
